text_scroll_ring: RTL and testbench

//   Scrolling controller for the text-mode character buffer, held as a ring of ROWS x COLS cells at START.

---
 rtl/text_scroll_ring.sv | 144 ++++++++++++++
 tb/tb_text_scroll_ring.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/text_scroll_ring.sv
// Scroll controller for a text-mode character ring buffer.
// Tracks the ring offset of the top visible row, translates logical cell
// indices to physical addresses, and clears the exposed rows while scrolling.
//
// state   | meaning
// IDLE    | waiting for a scroll request, scroll_ready high
// CLEAR   | writing CLEAR_CHAR across the exposed row, one cell per cycle
// ADVANCE | moving base_off down one row, then next row or back to IDLE
module text_scroll_ring #(
  parameter int WIDTH      = 15,
  parameter int COLS       = 80,
  parameter int ROWS       = 30,
  parameter int START      = 0,
  parameter int DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] CLEAR_CHAR = 16'h0720,
  parameter int LINES_W    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lookup_valid,
  input  logic [WIDTH-1:0]      lookup_idx,
  output logic                  lookup_rvalid,
  output logic [WIDTH-1:0]      lookup_addr,
  output logic                  lookup_oob,
  input  logic                  scroll_valid,
  input  logic [LINES_W-1:0]    scroll_lines,
  output logic                  scroll_ready,
  output logic                  clr_we,
  output logic [WIDTH-1:0]      clr_addr,
  output logic [DATA_WIDTH-1:0] clr_data,
  output logic [WIDTH-1:0]      base_off
);

  localparam int SIZE = COLS * ROWS;
  localparam logic [WIDTH:0]   SIZE_X  = (WIDTH+1)'(SIZE);
  localparam logic [WIDTH:0]   COLS_X  = (WIDTH+1)'(COLS);
  localparam logic [WIDTH-1:0] START_W = WIDTH'(START);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [CW-1:0]    COL_LAST = CW'(COLS - 1);
  localparam logic [31:0]      ROWS_U   = 32'(ROWS);

  typedef enum logic [1:0] {IDLE, CLEAR, ADVANCE} state_t;

  state_t               state;
  logic [CW-1:0]        col_cnt;
  logic [LINES_W-1:0]   rows_left;

  logic [WIDTH:0]       adv_sum;
  logic [WIDTH-1:0]     base_next;
  logic [LINES_W-1:0]   req_rows;
  logic [WIDTH:0]       lk_sum;
  logic [WIDTH:0]       lk_off;
  logic                 lk_oob;

  assign clr_data = CLEAR_CHAR;

  // Next ring offset one row down, wrapping to the start of the ring.
  always_comb begin
    adv_sum   = {1'b0, base_off} + COLS_X;
    base_next = (adv_sum == SIZE_X) ? '0 : adv_sum[WIDTH-1:0];
  end

  // Requests beyond the ring height clear every row exactly once.
  always_comb begin
    req_rows = scroll_lines;
    if (32'(scroll_lines) > ROWS_U) req_rows = LINES_W'(ROWS);
  end

  // Logical-to-physical translation; sum kept one bit wider so it cannot overflow.
  always_comb begin
    lk_sum = {1'b0, base_off} + {1'b0, lookup_idx};
    lk_off = (lk_sum >= SIZE_X) ? (lk_sum - SIZE_X) : lk_sum;
    lk_oob = ({1'b0, lookup_idx} >= SIZE_X);
  end

  // One-cycle lookup pipeline, independent of scrolling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lookup_rvalid <= 1'b0;
      lookup_addr   <= '0;
      lookup_oob    <= 1'b0;
    end else begin
      lookup_rvalid <= lookup_valid;
      if (lookup_valid) begin
        lookup_oob  <= lk_oob;
        lookup_addr <= lk_oob ? START_W : (START_W + lk_off[WIDTH-1:0]);
      end
    end
  end

  // Scroll sequencer: column and row down-counters with terminal-count compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      base_off     <= '0;
      scroll_ready <= 1'b1;
      clr_we       <= 1'b0;
      clr_addr     <= '0;
      col_cnt      <= '0;
      rows_left    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (scroll_valid && req_rows != '0) begin
            state        <= CLEAR;
            scroll_ready <= 1'b0;
            clr_we       <= 1'b1;
            clr_addr     <= START_W + base_off;
            col_cnt      <= COL_LAST;
            rows_left    <= req_rows;
          end
        end
        CLEAR: begin
          if (col_cnt == '0) begin
            state  <= ADVANCE;
            clr_we <= 1'b0;
          end else begin
            clr_addr <= clr_addr + WIDTH'(1);
            col_cnt  <= col_cnt - CW'(1);
          end
        end
        ADVANCE: begin
          base_off  <= base_next;
          rows_left <= rows_left - LINES_W'(1);
          if (rows_left == LINES_W'(1)) begin
            state        <= IDLE;
            scroll_ready <= 1'b1;
          end else begin
            state    <= CLEAR;
            clr_we   <= 1'b1;
            clr_addr <= START_W + base_next;
            col_cnt  <= COL_LAST;
          end
        end
        default: begin
          state        <= IDLE;
          scroll_ready <= 1'b1;
          clr_we       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_scroll_ring.sv
// Self-checking bench for text_scroll_ring with a small 4x3 ring at address 100.
module tb_text_scroll_ring;

  localparam int WIDTH = 15;
  localparam int COLS  = 4;
  localparam int ROWS  = 3;
  localparam int START = 100;
  localparam int SIZE  = COLS * ROWS;
  localparam int LW    = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             lookup_valid = 1'b0;
  logic [WIDTH-1:0] lookup_idx = '0;
  logic             lookup_rvalid;
  logic [WIDTH-1:0] lookup_addr;
  logic             lookup_oob;
  logic             scroll_valid = 1'b0;
  logic [LW-1:0]    scroll_lines = '0;
  logic             scroll_ready;
  logic             clr_we;
  logic [WIDTH-1:0] clr_addr;
  logic [15:0]      clr_data;
  logic [WIDTH-1:0] base_off;

  int tests = 0;
  int fails = 0;
  int base_m = 0;
  int wr_q[$];

  text_scroll_ring #(
    .WIDTH(WIDTH), .COLS(COLS), .ROWS(ROWS), .START(START),
    .DATA_WIDTH(16), .CLEAR_CHAR(16'h0720), .LINES_W(LW)
  ) dut (
    .clk(clk), .rst(rst),
    .lookup_valid(lookup_valid), .lookup_idx(lookup_idx),
    .lookup_rvalid(lookup_rvalid), .lookup_addr(lookup_addr), .lookup_oob(lookup_oob),
    .scroll_valid(scroll_valid), .scroll_lines(scroll_lines), .scroll_ready(scroll_ready),
    .clr_we(clr_we), .clr_addr(clr_addr), .clr_data(clr_data), .base_off(base_off)
  );

  always #5 clk = ~clk;

  // Record every clear write mid-cycle.
  always @(negedge clk) if (clr_we === 1'b1) wr_q.push_back(int'(clr_addr));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_addr(input int base, input int idx);
    if (idx >= SIZE) return START;
    return START + (base + idx) % SIZE;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input int idx);
    lookup_valid = 1'b1;
    lookup_idx   = WIDTH'(idx);
    tick();
    lookup_valid = 1'b0;
    chk("lk_rvalid", 32'(lookup_rvalid), 1);
    chk("lk_addr", 32'(lookup_addr), ref_addr(base_m, idx));
    chk("lk_oob", 32'(lookup_oob), (idx >= SIZE) ? 1 : 0);
  endtask

  task automatic do_scroll(input int lines, input bit rnd_lk);
    int n, cyc, base0, idx, k;
    n     = (lines > ROWS) ? ROWS : lines;
    base0 = base_m;
    idx   = 0;
    wr_q.delete();
    chk("ready_before", 32'(scroll_ready), 1);
    scroll_valid = 1'b1;
    scroll_lines = LW'(lines);
    tick();
    scroll_valid = 1'b0;
    cyc = 0;
    while (scroll_ready !== 1'b1 && cyc < 200) begin
      if (rnd_lk) begin
        idx          = $urandom_range(0, SIZE + 3);
        lookup_valid = 1'b1;
        lookup_idx   = WIDTH'(idx);
      end
      // a request while busy must be dropped, not queued
      scroll_valid = (cyc == 2);
      scroll_lines = LW'(1);
      tick();
      cyc++;
      if (rnd_lk) begin
        chk("busy_lk_rvalid", 32'(lookup_rvalid), 1);
        chk("busy_lk_addr", 32'(lookup_addr),
            ref_addr((base0 + ((cyc - 1) / (COLS + 1)) * COLS) % SIZE, idx));
      end
    end
    lookup_valid = 1'b0;
    scroll_valid = 1'b0;
    chk("scroll_cycles", cyc, n * (COLS + 1));
    base_m = (base0 + n * COLS) % SIZE;
    chk("base_off", 32'(base_off), base_m);
    chk("clr_we_idle", 32'(clr_we), 0);
    chk("wr_count", wr_q.size(), n * COLS);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < COLS; c++) begin
        k = r * COLS + c;
        if (k < wr_q.size())
          chk("wr_addr", wr_q[k], START + (base0 + r * COLS) % SIZE + c);
      end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(scroll_ready), 1);
    chk("rst_clr_we", 32'(clr_we), 0);
    chk("rst_clr_addr", 32'(clr_addr), 0);
    chk("rst_base", 32'(base_off), 0);
    chk("rst_rvalid", 32'(lookup_rvalid), 0);
    chk("rst_lk_addr", 32'(lookup_addr), 0);
    chk("rst_oob", 32'(lookup_oob), 0);
    chk("clr_data", 32'(clr_data), 32'h0720);
    rst = 1'b0;
    tick();

    lookup(5);
    chk("spec_lk5", 32'(lookup_addr), 105);

    do_scroll(1, 1'b0);
    chk("spec_base4", 32'(base_off), 4);
    lookup(9);
    chk("spec_lk9", 32'(lookup_addr), 101);
    lookup(7);
    chk("spec_lk7", 32'(lookup_addr), 111);

    do_scroll(1, 1'b1);
    do_scroll(2, 1'b0);
    chk("spec_wrap_base", 32'(base_off), 4);
    do_scroll(2, 1'b1);
    do_scroll(5, 1'b0);
    chk("spec_clamp_base", 32'(base_off), 0);
    do_scroll(0, 1'b0);

    lookup(12);
    chk("spec_oob_addr", 32'(lookup_addr), 100);

    for (int i = 0; i < 8; i++) begin
      do_scroll($urandom_range(0, 7), 1'b1);
      lookup($urandom_range(0, SIZE + 2));
    end

    if (base_m == 0) do_scroll(1, 1'b0);
    wr_q.delete();
    scroll_valid = 1'b1;
    scroll_lines = LW'(2);
    tick();
    scroll_valid = 1'b0;
    tick();
    chk("mid_clr_we", 32'(clr_we), 1);
    chk("mid_clr_addr", 32'(clr_addr), START + base_m + 1);
    rst = 1'b1;
    #1;
    chk("async_clr_we", 32'(clr_we), 0);
    chk("async_base", 32'(base_off), 0);
    chk("async_ready", 32'(scroll_ready), 1);
    tick();
    tick();
    rst = 1'b0;
    base_m = 0;
    wr_q.delete();
    repeat (12) tick();
    chk("post_rst_writes", wr_q.size(), 0);
    chk("post_rst_ready", 32'(scroll_ready), 1);
    chk("post_rst_base", 32'(base_off), 0);
    lookup(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
